// File: rtl/idct8_row_feeder_pkg.sv
// Shared constants for the 8-point systolic IDCT: widths, pass encoding,
// per-pass shift/rounding values and the feeder-to-chain latency.
package idct8_row_feeder_pkg;

  localparam int IDCT_DW       = 25;
  localparam int IDCT_CW       = 16;
  localparam int IDCT_SHIFT_P0 = 7;
  localparam int IDCT_SHIFT_P1 = 12;
  localparam int IDCT_ADD_P0   = 1 << (IDCT_SHIFT_P0 - 1);
  localparam int IDCT_ADD_P1   = 1 << (IDCT_SHIFT_P1 - 1);
  localparam int IDCT_FEED_LAT = 9;
  localparam int IDCT_SHW      = 4;

  typedef enum logic {
    PASS_FIRST  = 1'b0,
    PASS_SECOND = 1'b1
  } pass_e;

endpackage

// File: rtl/idct8_row_feeder_skew_line.sv
// N-deep DW-bit delay line with asynchronous active-low clear.
module idct_skew_line
  import idct8_row_feeder_pkg::*;
#(
  parameter int N  = 1,
  parameter int DW = IDCT_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout
);

  logic signed [DW-1:0] sr_q [N];
  logic signed [DW-1:0] sr_d [N];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < N; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[N-1];

endmodule

// File: rtl/idct8_row_feeder.sv
// Row feeder for the systolic IDCT chain: skews a coefficient row across the
// eight chain inputs, delays the per-pass rounding config, tags results, meters credits.
module idct8_row_feeder
  import idct8_row_feeder_pkg::*;
#(
  parameter int DW       = IDCT_DW,
  parameter int CW       = IDCT_CW,
  parameter int CREDITS  = 16,
  parameter int SHIFT_P0 = IDCT_SHIFT_P0,
  parameter int SHIFT_P1 = IDCT_SHIFT_P1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] in_coef_0,
  input  logic signed [CW-1:0] in_coef_1,
  input  logic signed [CW-1:0] in_coef_2,
  input  logic signed [CW-1:0] in_coef_3,
  input  logic signed [CW-1:0] in_coef_4,
  input  logic signed [CW-1:0] in_coef_5,
  input  logic signed [CW-1:0] in_coef_6,
  input  logic signed [CW-1:0] in_coef_7,
  input  logic                 in_last,
  input  logic                 pass_sel,
  output logic signed [DW-1:0] d_in_1,
  output logic signed [DW-1:0] d_in_2,
  output logic signed [DW-1:0] d_in_3,
  output logic signed [DW-1:0] d_in_4,
  output logic signed [DW-1:0] d_in_5,
  output logic signed [DW-1:0] d_in_6,
  output logic signed [DW-1:0] d_in_7,
  output logic signed [DW-1:0] d_in_8,
  output logic        [DW-1:0] add,
  output logic [IDCT_SHW-1:0]  shift,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 credit_ret,
  output logic                 err_credit
);

  localparam int CNT_W = 8;
  localparam int LAT   = IDCT_FEED_LAT;

  function automatic logic [DW-1:0] round_add(input logic [IDCT_SHW-1:0] sh);
    logic [DW-1:0] one;
    one = {{(DW-1){1'b0}}, 1'b1};
    if (sh == '0) return '0;
    return one << (sh - 4'd1);
  endfunction

  function automatic logic signed [DW-1:0] sext(input logic signed [CW-1:0] c);
    return {{(DW-CW){c[CW-1]}}, c};
  endfunction

  logic [CNT_W-1:0]    credit_q, credit_d;
  logic                err_q, err_d;
  logic                accept;
  logic [IDCT_SHW-1:0] shift_q [LAT];
  logic [IDCT_SHW-1:0] shift_d [LAT];
  logic [1:0]          tag_q [LAT];
  logic [1:0]          tag_d [LAT];
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic signed [CW-1:0] coef     [8];
  logic signed [DW-1:0] skew_in  [8];
  logic signed [DW-1:0] skew_out [8];

  assign coef[0] = in_coef_0;
  assign coef[1] = in_coef_1;
  assign coef[2] = in_coef_2;
  assign coef[3] = in_coef_3;
  assign coef[4] = in_coef_4;
  assign coef[5] = in_coef_5;
  assign coef[6] = in_coef_6;
  assign coef[7] = in_coef_7;

  assign in_ready = (credit_q != '0);
  assign accept   = in_valid && in_ready;

  // Bubble cycles feed zeros so idle slots contribute nothing to the chain.
  for (genvar k = 0; k < 8; k++) begin : g_skew
    assign skew_in[k] = accept ? sext(coef[k]) : '0;
    idct_skew_line #(.N(k + 1), .DW(DW)) u_line (
      .clk  (clk),
      .rst_n(reset_n),
      .din  (skew_in[k]),
      .dout (skew_out[k])
    );
  end

  assign d_in_1 = skew_out[0];
  assign d_in_2 = skew_out[1];
  assign d_in_3 = skew_out[2];
  assign d_in_4 = skew_out[3];
  assign d_in_5 = skew_out[4];
  assign d_in_6 = skew_out[5];
  assign d_in_7 = skew_out[6];
  assign d_in_8 = skew_out[7];

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (accept && !credit_ret) begin
      credit_d = credit_q - 1'b1;
    end else if (!accept && credit_ret) begin
      if (credit_q == CNT_W'(CREDITS)) err_d = 1'b1;
      else                             credit_d = credit_q + 1'b1;
    end
  end

  // Only the shift travels down the config pipe; add is derived from it at the output.
  always_comb begin
    shift_d[0] = '0;
    if (accept) begin
      shift_d[0] = (pass_sel == PASS_SECOND) ? IDCT_SHW'(SHIFT_P1) : IDCT_SHW'(SHIFT_P0);
    end
    tag_d[0] = {accept, accept & in_last};
    for (int i = 1; i < LAT; i++) begin
      shift_d[i] = shift_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
    out_valid_d = tag_q[LAT-1][1];
    out_last_d  = tag_q[LAT-1][0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q    <= CNT_W'(CREDITS);
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        shift_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      credit_q    <= credit_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      shift_q     <= shift_d;
      tag_q       <= tag_d;
    end
  end

  assign shift      = shift_q[LAT-1];
  assign add        = round_add(shift_q[LAT-1]);
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign err_credit = err_q;

endmodule

// File: tb/tb_idct8_row_feeder.sv
// Scoreboard bench for idct8_row_feeder with CREDITS = 4 and directed rows.
module tb_idct8_row_feeder;

  localparam int DW      = 25;
  localparam int CW      = 16;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, in_valid, in_last, pass_sel, credit_ret;
  logic                 in_ready, out_valid, out_last, err_credit;
  logic signed [CW-1:0] coef_drv [8];
  logic signed [DW-1:0] d_in_1, d_in_2, d_in_3, d_in_4, d_in_5, d_in_6, d_in_7, d_in_8;
  logic signed [DW-1:0] dmon [8];
  logic        [DW-1:0] add;
  logic [3:0]           shift;

  idct8_row_feeder #(.DW(DW), .CW(CW), .CREDITS(CREDITS), .SHIFT_P0(7), .SHIFT_P1(12)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef_0(coef_drv[0]), .in_coef_1(coef_drv[1]), .in_coef_2(coef_drv[2]),
    .in_coef_3(coef_drv[3]), .in_coef_4(coef_drv[4]), .in_coef_5(coef_drv[5]),
    .in_coef_6(coef_drv[6]), .in_coef_7(coef_drv[7]),
    .in_last(in_last), .pass_sel(pass_sel),
    .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
    .d_in_5(d_in_5), .d_in_6(d_in_6), .d_in_7(d_in_7), .d_in_8(d_in_8),
    .add(add), .shift(shift), .out_valid(out_valid), .out_last(out_last),
    .credit_ret(credit_ret), .err_credit(err_credit)
  );

  assign dmon[0] = d_in_1;
  assign dmon[1] = d_in_2;
  assign dmon[2] = d_in_3;
  assign dmon[3] = d_in_4;
  assign dmon[4] = d_in_5;
  assign dmon[5] = d_in_6;
  assign dmon[6] = d_in_7;
  assign dmon[7] = d_in_8;

  // Reference model state: accepted-row history by edge number and a tag queue.
  typedef struct {
    int   due;
    logic last;
  } exp_t;

  exp_t                 q[$];
  int                   cyc = 0;
  int                   cnt_m = CREDITS;
  logic                 err_m = 1'b0;
  logic                 hist_v [64];
  logic                 hist_p [64];
  logic signed [CW-1:0] hist_c [64][8];
  int                   n_cmp = 0;
  int                   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_m <= CREDITS;
      err_m <= 1'b0;
      for (int i = 0; i < 64; i++) hist_v[i] <= 1'b0;
      q.delete();
    end else begin
      hist_v[(cyc + 1) % 64] <= in_valid && (cnt_m > 0);
      hist_p[(cyc + 1) % 64] <= pass_sel;
      for (int k = 0; k < 8; k++) hist_c[(cyc + 1) % 64][k] <= coef_drv[k];
      if (in_valid && (cnt_m > 0)) q.push_back('{due: cyc + 10, last: in_last});
      if (in_valid && (cnt_m > 0) && !credit_ret)       cnt_m <= cnt_m - 1;
      else if (!(in_valid && (cnt_m > 0)) && credit_ret) begin
        if (cnt_m == CREDITS) err_m <= 1'b1;
        else                  cnt_m <= cnt_m + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic signed [DW-1:0] e_d;
    int                   idx;
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) chk($sformatf("rst_d_in_%0d", k + 1), 64'(dmon[k]), 64'(0));
      chk("rst_add", 64'(add), 64'(0));
      chk("rst_shift", 64'(shift), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_err_credit", 64'(err_credit), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      return;
    end
    chk("in_ready", 64'(in_ready), 64'(cnt_m > 0));
    chk("err_credit", 64'(err_credit), 64'(err_m));
    for (int k = 0; k < 8; k++) begin
      e_d = '0;
      if (cyc >= k && hist_v[(cyc - k) % 64]) e_d = hist_c[(cyc - k) % 64][k];
      chk($sformatf("d_in_%0d", k + 1), 64'(dmon[k]), 64'(e_d));
    end
    idx = (cyc - 8) % 64;
    if (cyc >= 8 && hist_v[idx]) begin
      chk("shift", 64'(shift), hist_p[idx] ? 64'(12) : 64'(7));
      chk("add", 64'(add), hist_p[idx] ? 64'(2048) : 64'(64));
    end else begin
      chk("shift_bubble", 64'(shift), 64'(0));
      chk("add_bubble", 64'(add), 64'(0));
    end
    while (q.size() > 0 && q[0].due < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL out_valid_missing cyc=%0d got=none want=due_%0d", cyc, q[0].due);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("out_last", 64'(out_last), 64'(q[0].last));
      void'(q.pop_front());
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'(0));
      chk("out_last_idle", 64'(out_last), 64'(0));
    end
  endtask

  always @(negedge clk) check_cycle();

  task automatic step(input logic v, input int r[8], input logic p, input logic l, input logic ret);
    in_valid = v;
    for (int k = 0; k < 8; k++) coef_drv[k] = CW'(r[k]);
    pass_sel   = p;
    in_last    = l;
    credit_ret = ret;
    @(posedge clk);
    #2;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    credit_ret = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int z[8];
    int r[8];
    z = '{default: 0};
    reset_n    = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    pass_sel   = 1'b0;
    credit_ret = 1'b0;
    for (int k = 0; k < 8; k++) coef_drv[k] = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(2);

    // single impulse row, first pass
    step(1'b1, '{1, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0);
    idle(12);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(2);

    // skew ramp then negative ramp on the second pass
    step(1'b1, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 1'b0, 1'b0);
    step(1'b1, '{-1, -2, -3, -4, -5, -6, -7, -8}, 1'b1, 1'b1, 1'b0);
    idle(12);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(2);

    // credit exhaustion: five offered, four fit
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 8; k++) r[k] = 16 * i + k + 3;
      step(1'b1, r, 1'b0, 1'b0, 1'b0);
    end
    idle(3);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    step(1'b1, '{100, -100, 200, -200, 300, -300, 400, -400}, 1'b1, 1'b0, 1'b1);
    idle(1);
    step(1'b1, '{32767, -32768, 0, 1, -1, 2, -2, 3}, 1'b0, 1'b1, 1'b0);
    idle(12);
    repeat (4) step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(2);

    // alternating passes, last on the eighth row
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) r[k] = (i + 1) * (k - 3);
      step(1'b1, r, 1'(i % 2), 1'(i == 7), 1'(i > 0));
    end
    idle(12);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(2);

    // reset while three rows are in flight
    step(1'b1, '{5, 6, 7, 8, 9, 10, 11, 12}, 1'b0, 1'b0, 1'b0);
    step(1'b1, '{-5, -6, -7, -8, -9, -10, -11, -12}, 1'b1, 1'b1, 1'b0);
    step(1'b1, '{7, 7, 7, 7, 7, 7, 7, 7}, 1'b0, 1'b0, 1'b0);
    idle(2);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(14);

    // credit overflow: sticky error, count held
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, '{9, 8, 7, 6, 5, 4, 3, 2}, 1'b1, 1'b0, 1'b0);
    idle(12);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
